// File: rtl/priority_pkg.sv
// priority_pkg
//   Constants and state encoding shared by the 8-line priority encoder and
//   its consumer, priority_grant_decoder8.
package priority_pkg;
    localparam int CODE_W  = 3;
    localparam int N_LINES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/onehot_decode3to8.sv
// onehot_decode3to8
//   Combinational binary-to-one-hot decoder with enable.
//   en      in   1        drive a one-hot output when high, zero otherwise
//   code    in   CODE_W   binary line index
//   onehot  out  N_LINES  bit[code] set when en=1
module onehot_decode3to8
    import priority_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [N_LINES-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot = N_LINES'(1) << code;
    end
endmodule

// File: rtl/priority_grant_decoder8.sv
// priority_grant_decoder8
//   Consumer side of the 8-line priority encoder link. Takes {code, valid}
//   through a ready handshake, drives a registered one-hot grant until the
//   agent reports done or the hold limit expires, then idles HOLDOFF cycles
//   so the encoder inputs settle before the next accept.
//   clk           in   1      rising-edge clock
//   rst_n         in   1      synchronous active-low reset
//   code          in   3      encoded request index (sampled only on accept)
//   valid         in   1      encoder has a request
//   ready         out  1      decoder accepts this cycle (IDLE)
//   req_done      in   1      granted agent finished (GRANT only)
//   grant         out  8      one-hot grant
//   grant_code    out  3      index of current/last grant
//   busy          out  1      GRANT or HOLD
//   timeout       out  1      one-cycle pulse on forced release
//   grants_total  out  CNT_W  accepted-request count, wrapping
module priority_grant_decoder8
    import priority_pkg::*;
#(
    parameter int GRANT_MAX = 16,
    parameter int HOLDOFF   = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CODE_W-1:0]  code,
    input  logic               valid,
    output logic               ready,
    input  logic               req_done,
    output logic [N_LINES-1:0] grant,
    output logic [CODE_W-1:0]  grant_code,
    output logic               busy,
    output logic               timeout,
    output logic [CNT_W-1:0]   grants_total
);
    // One counter serves both the grant hold and the holdoff, so it is
    // sized for whichever limit is larger.
    localparam int CMAX = (GRANT_MAX > HOLDOFF) ? GRANT_MAX : HOLDOFF;
    localparam int HC_W = $clog2(CMAX + 1);
    localparam logic [HC_W-1:0] GRANT_LAST = HC_W'(GRANT_MAX - 1);
    localparam logic [HC_W-1:0] HOLD_LAST  = (HOLDOFF > 0) ? HC_W'(HOLDOFF - 1) : '0;

    state_t             state_q, state_n;
    logic [HC_W-1:0]    cnt_q, cnt_n;
    logic [CODE_W-1:0]  code_n;
    logic [N_LINES-1:0] grant_n;
    logic [CNT_W-1:0]   total_n;
    logic               to_n;
    logic               grant_en;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        code_n  = grant_code;
        total_n = grants_total;
        to_n    = 1'b0;
        case (state_q)
            IDLE: begin
                // code is only looked at here, so X on code while valid=0 is harmless
                if (valid && ready) begin
                    state_n = GRANT;
                    cnt_n   = '0;
                    code_n  = code;
                    total_n = grants_total + 1'b1;
                end
            end
            GRANT: begin
                // done takes priority over expiry: no timeout pulse if both
                if (req_done || cnt_q == GRANT_LAST) begin
                    to_n    = !req_done;
                    cnt_n   = '0;
                    state_n = (HOLDOFF == 0) ? IDLE : HOLD;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Decode from the next-state values so the registered grant lines up
    // with the registered state (one cycle accept->grant).
    assign grant_en = (state_n == GRANT);

    onehot_decode3to8 u_dec (
        .en     (grant_en),
        .code   (code_n),
        .onehot (grant_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant        <= '0;
            grant_code   <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
            grants_total <= '0;
            ready        <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            grant        <= grant_n;
            grant_code   <= code_n;
            busy         <= (state_n != IDLE);
            timeout      <= to_n;
            grants_total <= total_n;
            ready        <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_priority_grant_decoder8.sv
// tb_priority_grant_decoder8
//   Directed stimulus pushes one expected grant record per accept; a monitor
//   on the falling edge pops a record on every new grant and checks code,
//   count, one-hot value, hold length, timeout pulse and holdoff length.
//   grants_total is 4 bits wide here so the wrap 15 -> 0 is reached with a
//   short run of quick grants.
module tb_priority_grant_decoder8;
    import priority_pkg::*;

    localparam int GMAX = 16;
    localparam int HOFF = 2;
    localparam int CW   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CODE_W-1:0]  code;
    logic               valid;
    logic               ready;
    logic               req_done;
    logic [N_LINES-1:0] grant;
    logic [CODE_W-1:0]  grant_code;
    logic               busy;
    logic               timeout;
    logic [CW-1:0]      grants_total;

    priority_grant_decoder8 #(.GRANT_MAX(GMAX), .HOLDOFF(HOFF), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code         (code),
        .valid        (valid),
        .ready        (ready),
        .req_done     (req_done),
        .grant        (grant),
        .grant_code   (grant_code),
        .busy         (busy),
        .timeout      (timeout),
        .grants_total (grants_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    g;
        logic [2:0]    c;
        logic [CW-1:0] tot;
        int            len;   // 0: grant is cut short by reset, skip release checks
        bit            to;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t cur;
    bit   in_g     = 0;
    int   glen     = 0;
    bit   hold_act = 0;
    int   hold_n   = 0;

    always @(negedge clk) begin
        if (!in_g && grant != 0) begin
            if (q.size() == 0) begin
                check("unexpected_grant", 32'(grant), 32'h0);
            end else begin
                cur = q.pop_front();
                check("grant_value", 32'(grant), 32'(cur.g));
                check("grant_code", 32'(grant_code), 32'(cur.c));
                check("grants_total", 32'(grants_total), 32'(cur.tot));
                check("busy_in_grant", 32'(busy), 32'h1);
                in_g = 1;
                glen = 1;
            end
        end else if (in_g && grant != 0) begin
            glen++;
            check("grant_stable", 32'(grant), 32'(cur.g));
            check("no_early_timeout", 32'(timeout), 32'h0);
        end else if (in_g && grant == 0) begin
            in_g = 0;
            if (cur.len != 0) begin
                check("grant_length", 32'(glen), 32'(cur.len));
                check("timeout_on_release", 32'(timeout), 32'(cur.to));
                check("busy_on_release", 32'(busy), 32'h1);
                check("ready_on_release", 32'(ready), 32'h0);
                check("code_held", 32'(grant_code), 32'(cur.c));
                hold_act = 1;
                hold_n   = 1;
            end
        end else begin
            if (hold_act) begin
                if (busy) begin
                    hold_n++;
                end else begin
                    check("holdoff_length", 32'(hold_n), HOFF);
                    check("ready_after_hold", 32'(ready), 32'h1);
                    hold_act = 0;
                end
            end
            if (timeout) check("spurious_timeout", 32'(timeout), 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) check("ready_wait_bound", 32'(ready), 32'h1);
    endtask

    // Issue one request; done_at=k raises req_done in the k-th GRANT cycle,
    // done_at=0 never raises it.
    task automatic do_grant(input logic [2:0] c, input logic [7:0] eg, input logic [CW-1:0] et,
                            input int done_at, input int elen, input bit eto);
        exp_t e;
        e.g = eg; e.c = c; e.tot = et; e.len = elen; e.to = eto;
        wait_ready();
        q.push_back(e);
        valid = 1'b1;
        code  = c;
        @(posedge clk); #1;
        valid = 1'b0;
        code  = 3'd4;          // ignored outside an accept
        if (done_at > 0) begin
            repeat (done_at - 1) begin @(posedge clk); #1; end
            req_done = 1'b1;
            @(posedge clk); #1;
            req_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b1;
        code     = 3'd5;
        req_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_code", 32'(grant_code), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_total", 32'(grants_total), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);

        // 1: code 5 held through reset; ready rises one cycle after release
        rst_n = 1'b1;
        begin
            exp_t e;
            e.g = 8'h20; e.c = 3'd5; e.tot = 4'd1; e.len = 1; e.to = 0;
            q.push_back(e);
        end
        @(posedge clk); #1;
        check("ready_cycle1", 32'(ready), 32'h1);
        check("no_grant_cycle1", 32'(grant), 32'h0);
        @(posedge clk); #1;            // accept edge
        valid = 1'b0;
        check("grant_latency", 32'(grant), 32'h20);
        req_done = 1'b1;
        @(posedge clk); #1;
        req_done = 1'b0;

        // 2: done in 3rd GRANT cycle
        do_grant(3'd7, 8'h80, 4'd2, 3, 3, 0);
        // 3: never done -> 16-cycle grant, timeout pulse
        do_grant(3'd0, 8'h01, 4'd3, 0, 16, 1);
        // 4: done exactly on the expiry cycle -> no timeout
        do_grant(3'd2, 8'h04, 4'd4, 16, 16, 0);

        // 5: reset mid-GRANT
        do_grant(3'd3, 8'h08, 4'd5, 0, 0, 0);
        @(posedge clk); #1;            // GRANT cycle 2
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_total", 32'(grants_total), 32'h0);
        check("midrst_timeout", 32'(timeout), 32'h0);
        check("midrst_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_no_grant", 32'(grant), 32'h0);
        check("idle_ready", 32'(ready), 32'h1);

        // 6: bring the count to 15, then three requests with the wrap
        for (int i = 1; i <= 15; i++) begin
            logic [7:0] eg;
            eg = 8'h01 << (i % 8);
            do_grant(3'(i % 8), eg, 4'(i), 1, 1, 0);
        end
        do_grant(3'd1, 8'h02, 4'd0, 2, 2, 0);
        do_grant(3'd2, 8'h04, 4'd1, 2, 2, 0);
        do_grant(3'd6, 8'h40, 4'd2, 2, 2, 0);

        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);
        check("final_total", 32'(grants_total), 32'h2);
        check("final_code", 32'(grant_code), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
